video_timex: RTL and testbench

Parametrised successor to the fixed 48K ULA video generator. It produces raster timing, VRAM fetch addresses, pixel/attribute serialisation and the frame interrupt. Horizontal and vertical timing are generic, so 48K and 128K geometries come from one block. A frame-latched mode input adds Timex alternate-screen and hi-colour (8x1 attribute) modes. It sits between the VRAM port (14-bit address, 8-bit data) and the RGBI/sync output stage.

---
 rtl/video_pkg.sv | 49 ++++
 rtl/video_counter.sv | 57 +++++
 rtl/video_timex.sv | 184 ++++++++++++++++++
 tb/tb_video_timex.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the video_timex raster generator.
//   - mode_e      : frame-latched display mode (standard screen 0/1, hi-colour)
//   - raster_t    : bundle of combinational raster timing flags
//   - fetch_t     : bitmap/attribute bytes captured from VRAM
//   - 48K / 128K default line and frame geometries
//   - decode_mode : maps the raw 2-bit mode input (11 folds onto screen 0)
//   - in_range    : inclusive counter range test used for sync/blank windows
package video_pkg;

  localparam int CNT_W        = 9;   // wide enough for both 448- and 456-clock lines
  localparam int H_TOTAL_48K  = 448;
  localparam int V_TOTAL_48K  = 312;
  localparam int H_TOTAL_128K = 456;
  localparam int V_TOTAL_128K = 311;

  typedef enum logic [1:0] {
    MODE_STD0  = 2'b00,
    MODE_STD1  = 2'b01,
    MODE_HICOL = 2'b10
  } mode_e;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
    logic irq;
  } raster_t;

  typedef struct packed {
    logic [7:0] bmp;
    logic [7:0] atr;
  } fetch_t;

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_STD1;
      2'b10:   return MODE_HICOL;
      default: return MODE_STD0;
    endcase
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/video_counter.sv
// video_counter: horizontal, vertical and frame counters for the raster.
//   clock, reset (async, active high), ce (pixel-clock enable)
//   h_count    : 0..H_TOTAL-1, pixel column within the line
//   v_count    : 0..V_TOTAL-1, line within the frame
//   flash      : frame counter bit FLASH_BIT (attribute flash phase)
//   h_wrap     : this ce cycle ends the line
//   frame_wrap : this ce cycle ends the frame (both counters wrap)
module video_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL   = H_TOTAL_48K,
  parameter int V_TOTAL   = V_TOTAL_48K,
  parameter int FLASH_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             flash,
  output logic             h_wrap,
  output logic             frame_wrap
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [4:0]       f_q, f_d;

  always_comb begin
    h_wrap     = (h_q == H_LAST);
    frame_wrap = h_wrap && (v_q == V_LAST);
    h_d        = h_wrap ? '0 : h_q + CNT_W'(1);
    v_d        = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    f_d        = frame_wrap ? f_q + 5'd1 : f_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
      f_q <= '0;
    end else if (ce) begin
      h_q <= h_d;
      v_q <= v_d;
      f_q <= f_d;
    end
  end

  assign h_count = h_q;
  assign v_count = v_q;
  assign flash   = f_q[FLASH_BIT];

endmodule

// File: rtl/video_timex.sv
// video_timex: parametrised raster generator with Timex screen modes.
//   clock, reset (async, active high), ce (pixel-clock enable)
//   mode   : 00 std screen 0, 01 std screen 1, 10 hi-colour, 11 as 00;
//            sampled only at the frame wrap
//   border : border colour, GRB
//   d      : VRAM data, valid the ce cycle after a changes
//   a      : VRAM address (bitmap on hCount[1]=0, attribute on hCount[1]=1)
//   blank/hblank/vblank/hsync/vsync/irq : combinational raster flags
//   r,g,b,i: pixel colour; pixel (x,y) appears at hCount = x+13 on line y
module video_timex
  import video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_48K,
  parameter int V_TOTAL      = V_TOTAL_48K,
  parameter int HBLANK_START = 320,
  parameter int HBLANK_END   = 415,
  parameter int HSYNC_START  = 344,
  parameter int HSYNC_END    = 375,
  parameter int VBLANK_START = 248,
  parameter int VBLANK_END   = 255,
  parameter int VSYNC_START  = 248,
  parameter int VSYNC_END    = 251,
  parameter int INT_LINE     = 248,
  parameter int INT_HPOS     = 0,
  parameter int INT_LEN      = 32,
  parameter int FLASH_BIT    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [1:0]  mode,
  input  logic [2:0]  border,
  input  logic [7:0]  d,
  output logic [13:0] a,
  output logic        blank,
  output logic        hblank,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        irq
);

  localparam logic [CNT_W-1:0] HB_S  = CNT_W'(HBLANK_START);
  localparam logic [CNT_W-1:0] HB_E  = CNT_W'(HBLANK_END);
  localparam logic [CNT_W-1:0] HS_S  = CNT_W'(HSYNC_START);
  localparam logic [CNT_W-1:0] HS_E  = CNT_W'(HSYNC_END);
  localparam logic [CNT_W-1:0] VB_S  = CNT_W'(VBLANK_START);
  localparam logic [CNT_W-1:0] VB_E  = CNT_W'(VBLANK_END);
  localparam logic [CNT_W-1:0] VS_S  = CNT_W'(VSYNC_START);
  localparam logic [CNT_W-1:0] VS_E  = CNT_W'(VSYNC_END);
  localparam logic [CNT_W-1:0] IRQ_V = CNT_W'(INT_LINE);
  localparam logic [CNT_W-1:0] IRQ_S = CNT_W'(INT_HPOS);
  // one bit wider so a window ending exactly at the counter range still works
  localparam logic [CNT_W:0]   IRQ_E = (CNT_W+1)'(INT_HPOS + INT_LEN);
  localparam logic [CNT_W-1:0] ACT_V = CNT_W'(191);

  logic [CNT_W-1:0] h, v;
  logic             flash, h_wrap, frame_wrap;

  video_counter #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .FLASH_BIT(FLASH_BIT)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .h_count   (h),
    .v_count   (v),
    .flash     (flash),
    .h_wrap    (h_wrap),
    .frame_wrap(frame_wrap)
  );

  // ---------------- state ----------------
  mode_e      mode_lat_q, mode_lat_d;
  fetch_t     fetch_q, fetch_d;
  logic       vid_en_q, vid_en_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] attr_q, attr_d;

  // ---------------- raster timing ----------------
  raster_t rst_flags;
  logic    data_en;
  logic [7:0] y;
  logic [4:0] c;

  always_comb begin
    rst_flags.hblank = in_range(h, HB_S, HB_E);
    rst_flags.vblank = in_range(v, VB_S, VB_E);
    rst_flags.hsync  = in_range(h, HS_S, HS_E);
    rst_flags.vsync  = in_range(v, VS_S, VS_E);
    rst_flags.irq    = (v == IRQ_V) && (h >= IRQ_S) && ({1'b0, h} < IRQ_E);
  end

  assign hblank = rst_flags.hblank;
  assign vblank = rst_flags.vblank;
  assign hsync  = rst_flags.hsync;
  assign vsync  = rst_flags.vsync;
  assign irq    = rst_flags.irq;
  assign blank  = rst_flags.hblank | rst_flags.vblank;

  // active area is 256x192; h <= 255 is simply h[8] == 0
  assign data_en = !h[CNT_W-1] && (v <= ACT_V);
  assign y       = v[7:0];
  // two columns per 16-clock group: hCount[2] picks the even/odd cell
  assign c       = {h[7:4], h[2]};

  // ---------------- VRAM addressing ----------------
  logic        scr;
  logic [13:0] bmp_addr, atr_addr;

  always_comb begin
    scr      = (mode_lat_q == MODE_STD1);
    bmp_addr = {scr, y[7:6], y[2:0], y[5:3], c};
    // hi-colour reads a per-line attribute from the screen-1 bitmap layout
    if (mode_lat_q == MODE_HICOL) atr_addr = {1'b1, y[7:6], y[2:0], y[5:3], c};
    else                          atr_addr = {scr, 3'b110, y[7:6], y[5:3], c};
    a = h[1] ? atr_addr : bmp_addr;
  end

  // ---------------- fetch / serialise ----------------
  always_comb begin
    mode_lat_d = mode_lat_q;
    fetch_d    = fetch_q;
    vid_en_d   = vid_en_q;
    shift_d    = {shift_q[6:0], 1'b0};
    attr_d     = attr_q;

    if (h_wrap && frame_wrap) mode_lat_d = decode_mode(mode);

    // phases 9/13 capture bitmap, 11/15 attribute: one ce after the address
    if (data_en && h[3] && h[0]) begin
      if (h[1]) fetch_d.atr = d;
      else      fetch_d.bmp = d;
    end

    if (h[3]) vid_en_d = data_en;

    // cell boundary: the load at hCount[2:0]=4 becomes visible on the next
    // clock, giving the fixed x+13 pixel latency
    if (h[2:0] == 3'd4) begin
      if (vid_en_q) begin
        shift_d = fetch_q.bmp;
        attr_d  = fetch_q.atr;
      end else begin
        shift_d = 8'h00;
        attr_d  = {2'b00, border, fetch_q.atr[2:0]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_lat_q <= MODE_STD0;
      fetch_q    <= '0;
      vid_en_q   <= 1'b0;
      shift_q    <= 8'h00;
      attr_q     <= 8'h00;
    end else if (ce) begin
      mode_lat_q <= mode_lat_d;
      fetch_q    <= fetch_d;
      vid_en_q   <= vid_en_d;
      shift_q    <= shift_d;
      attr_q     <= attr_d;
    end
  end

  // ---------------- colour ----------------
  logic sel;

  always_comb begin
    sel = shift_q[7] ^ (flash & attr_q[7]);
    r   = sel ? attr_q[1] : attr_q[4];
    g   = sel ? attr_q[2] : attr_q[5];
    b   = sel ? attr_q[0] : attr_q[3];
    i   = attr_q[6];
  end

endmodule

// File: tb/tb_video_timex.sv
// Directed bench for video_timex on a shrunk 280x6 raster: a VRAM model
// answers addresses one ce later, expectations are queued with the ce-count
// at which they must hold and compared as the run reaches that count.
module tb_video_timex;

  localparam int H = 280;
  localparam int V = 6;
  localparam int F = H * V;

  localparam int K_RGBI = 0;  // {r,g,b,i}
  localparam int K_ADDR = 1;  // a
  localparam int K_TIM  = 2;  // {blank,hblank,vblank,hsync,vsync,irq}

  logic        clock = 1'b0;
  logic        reset, ce;
  logic [1:0]  mode;
  logic [2:0]  border;
  logic [7:0]  d;
  logic [13:0] a;
  logic        blank, hblank, vblank, hsync, vsync, r, g, b, i, irq;

  logic [7:0] mem [0:16383];

  typedef struct {
    string       tag;
    int          pos;
    int          kind;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    pos;
  int    checks = 0;
  int    errors = 0;

  video_timex #(
    .H_TOTAL(H), .V_TOTAL(V),
    .HBLANK_START(260), .HBLANK_END(270),
    .HSYNC_START(262), .HSYNC_END(266),
    .VBLANK_START(4), .VBLANK_END(5),
    .VSYNC_START(4), .VSYNC_END(4),
    .INT_LINE(4), .INT_HPOS(0), .INT_LEN(32),
    .FLASH_BIT(4)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .mode(mode), .border(border),
    .d(d), .a(a), .blank(blank), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .i(i), .irq(irq)
  );

  always #5 clock = ~clock;

  // VRAM: data for the current address is presented on the following ce cycle
  always @(posedge clock) if (ce) d <= mem[a];

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] obs(input int kind);
    case (kind)
      K_RGBI:  return {12'd0, r, g, b, i};
      K_ADDR:  return {2'b00, a};
      default: return {10'd0, blank, hblank, vblank, hsync, vsync, irq};
    endcase
  endfunction

  function automatic int P(input int fr, input int ln, input int hc);
    return fr * F + ln * H + hc;
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge clock);
    #1;
    if (ce_v) pos++;
  endtask

  task automatic push(input string tag, input int p, input int kind, input logic [15:0] e);
    item_t it;
    it.tag = tag; it.pos = p; it.kind = kind; it.exp = e;
    sb.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      while (pos < it.pos) step(1'b1);
      if (pos != it.pos) begin
        checks++;
        errors++;
        $error("FAIL %s not reached in order: at=%0d wanted=%0d", it.tag, pos, it.pos);
      end else begin
        chk(it.tag, obs(it.kind), it.exp);
      end
    end
  endtask

  task automatic run_to(input int p);
    while (pos < p) step(1'b1);
  endtask

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 8'h00;
    mem[14'h0000] = 8'h80; mem[14'h1800] = 8'h47;
    mem[14'h001F] = 8'h01; mem[14'h181F] = 8'h07;
    mem[14'h2000] = 8'h80; mem[14'h3800] = 8'h47;

    reset = 1'b1; ce = 1'b0; mode = 2'b00; border = 3'b010; pos = 0;
    step(1'b1); step(1'b1); step(1'b1);
    chk("rst_addr", obs(K_ADDR), 16'h0000);
    chk("rst_rgbi", obs(K_RGBI), 16'h0000);
    chk("rst_tim",  obs(K_TIM),  16'h0000);
    reset = 1'b0;
    pos = 0;

    // mode 00, frame 0 line 0
    push("f0_bmp_addr", P(0,0,8),  K_ADDR, 16'h0000);
    push("f0_border",   P(0,0,8),  K_RGBI, 16'h0008);
    push("f0_atr_addr", P(0,0,10), K_ADDR, 16'h1800);
    push("f0_ink",      P(0,0,13), K_RGBI, 16'h000F);
    drain();

    // ce low holds everything
    step(1'b0); step(1'b0); step(1'b0);
    chk("freeze_rgbi", obs(K_RGBI), 16'h000F);
    chk("freeze_addr", obs(K_ADDR), 16'h0001);

    push("f0_paper",    P(0,0,14),  K_RGBI, 16'h0001);
    push("hb_pre",      P(0,0,259), K_TIM,  16'h0000);
    push("hb_on",       P(0,0,260), K_TIM,  16'h0030);
    push("hs_on",       P(0,0,262), K_TIM,  16'h0034);
    push("hs_off",      P(0,0,267), K_TIM,  16'h0030);
    push("col31_last",  P(0,0,268), K_RGBI, 16'h000E);
    push("border_post", P(0,0,269), K_RGBI, 16'h0008);
    push("hb_off",      P(0,0,271), K_TIM,  16'h0000);
    drain();

    // mid-frame switch to screen 1 only lands at the frame wrap
    run_to(P(0,2,0));
    mode = 2'b01;
    push("pre_wrap_scr0", P(0,3,8),  K_ADDR, 16'h0300);
    push("f1_bmp_addr",   P(1,0,8),  K_ADDR, 16'h2000);
    push("f1_atr_addr",   P(1,0,10), K_ADDR, 16'h3800);
    push("f1_ink",        P(1,0,13), K_RGBI, 16'h000F);
    push("f1_paper",      P(1,0,14), K_RGBI, 16'h0001);
    drain();

    // hi-colour: per-line attributes from the screen-1 area
    mode = 2'b10;
    mem[14'h2000] = 8'h0A; mem[14'h2100] = 8'h11; mem[14'h0100] = 8'h80;
    push("hc_l0_addr",  P(2,0,10), K_ADDR, 16'h2000);
    push("hc_l0_ink",   P(2,0,13), K_RGBI, 16'h0008);
    push("hc_l0_paper", P(2,0,14), K_RGBI, 16'h0002);
    push("hc_l1_addr",  P(2,1,10), K_ADDR, 16'h2100);
    push("hc_l1_ink",   P(2,1,13), K_RGBI, 16'h0002);
    push("hc_l1_paper", P(2,1,14), K_RGBI, 16'h0008);
    drain();

    // flash: ink red on black paper, all bitmap bits set
    mode = 2'b00;
    mem[14'h0000] = 8'hFF; mem[14'h1800] = 8'h82;
    push("flash_f3",  P(3,0,13),  K_RGBI, 16'h0008);
    push("flash_f15", P(15,0,13), K_RGBI, 16'h0008);
    push("flash_f16", P(16,0,13), K_RGBI, 16'h0000);
    push("flash_f31", P(31,0,13), K_RGBI, 16'h0000);
    push("flash_f32", P(32,0,13), K_RGBI, 16'h0008);
    drain();

    // reset mid-frame
    run_to(P(33,3,50));
    mode  = 2'b01;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", obs(K_ADDR), 16'h0000);
    chk("mid_rst_rgbi", obs(K_RGBI), 16'h0000);
    chk("mid_rst_tim",  obs(K_TIM),  16'h0000);
    step(1'b1); step(1'b1);
    chk("held_rst_rgbi", obs(K_RGBI), 16'h0000);
    chk("held_rst_addr", obs(K_ADDR), 16'h0000);
    reset = 1'b0;
    pos = 0;

    push("irq_pre",   P(0,3,279), K_TIM,  16'h0000);
    push("irq_on",    P(0,4,0),   K_TIM,  16'h002B);
    push("irq_last",  P(0,4,31),  K_TIM,  16'h002B);
    push("irq_off",   P(0,4,32),  K_TIM,  16'h002A);
    push("vb_l5",     P(0,5,0),   K_TIM,  16'h0028);
    push("last_addr", P(0,5,279), K_ADDR, 16'h1803);
    push("wrap_addr", P(1,0,0),   K_ADDR, 16'h2000);
    push("wrap_tim",  P(1,0,0),   K_TIM,  16'h0000);
    push("irq_f1",    P(1,4,0),   K_TIM,  16'h002B);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
